// File: rtl/cache_arb_pkg.sv
// Shared FSM states and default sizing for the cache request arbiter.
// Imported by the arbiter top and its round-robin picker.
package cache_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TAGS_WIDTH     = 48;
    localparam int DEF_CACHE_SIZE     = 512;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first asserted request above last_grant, else
// first asserted request at or below it (wrap-around scan).
module rr_picker
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic               any,
    output logic [GW-1:0]      winner
);

    logic          hi_any;
    logic          lo_any;
    logic [GW-1:0] hi_idx;
    logic [GW-1:0] lo_idx;

    // Descending scan so the lowest qualifying index is kept last.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (GW'(i) > last_grant) begin
                    hi_any = 1'b1;
                    hi_idx = GW'(i);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = GW'(i);
                end
            end
        end
        any    = hi_any | lo_any;
        winner = hi_any ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one cache frontend among NUM_REQ requesters, one lookup in
// flight, round-robin fair, with a bounded wait for the cache reply.
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TAGS_WIDTH     = DEF_TAGS_WIDTH,
    parameter int CACHE_SIZE     = DEF_CACHE_SIZE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_addr_tvalid,
    output logic [NUM_REQ-1:0]            req_addr_tready,
    input  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata,
    output logic [NUM_REQ-1:0]            rsp_data_tvalid,
    input  logic [NUM_REQ-1:0]            rsp_data_tready,
    output logic [CACHE_SIZE-1:0]         rsp_data_tdata,
    output logic                          cache_addr_tvalid,
    input  logic                          cache_addr_tready,
    output logic [TAGS_WIDTH-1:0]         cache_addr_tdata,
    input  logic                          cache_data_tvalid,
    output logic                          cache_data_tready,
    input  logic [CACHE_SIZE-1:0]         cache_data_tdata,
    output logic [GW-1:0]                 grant_id,
    output logic                          timeout_err
);

    arb_state_e            state;
    logic [GW-1:0]         last_grant;
    logic [TAGS_WIDTH-1:0] tag_q;
    logic [CACHE_SIZE-1:0] data_q;
    logic [TW-1:0]         timer;
    logic                  pick_any;
    logic [GW-1:0]         pick_idx;
    logic [TAGS_WIDTH-1:0] pick_tag;
    logic                  rsp_hs;

    rr_picker #(
        .NUM_REQ    (NUM_REQ),
        .GW         (GW)
    ) u_picker (
        .req        (req_addr_tvalid),
        .last_grant (last_grant),
        .any        (pick_any),
        .winner     (pick_idx)
    );

    always_comb begin
        pick_tag        = '0;
        req_addr_tready = '0;
        rsp_data_tvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == GW'(i)) begin
                pick_tag = req_addr_tdata[i*TAGS_WIDTH +: TAGS_WIDTH];
            end
            req_addr_tready[i] = !rst && (state == ST_IDLE) &&
                                 pick_any && (pick_idx == GW'(i));
            rsp_data_tvalid[i] = !rst && (state == ST_RESP) &&
                                 (grant_id == GW'(i));
        end
    end

    assign rsp_hs            = |(rsp_data_tvalid & rsp_data_tready);
    assign cache_addr_tvalid = !rst && (state == ST_ISSUE);
    assign cache_addr_tdata  = tag_q;
    assign rsp_data_tdata    = data_q;
    // Beats outside WAIT are accepted and simply dropped.
    assign cache_data_tready = !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= GW'(NUM_REQ - 1);
            grant_id    <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        tag_q    <= pick_tag;
                        grant_id <= pick_idx;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cache_addr_tready) begin
                        timer <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Real data beats a coincident timeout.
                    if (cache_data_tvalid) begin
                        data_q <= cache_data_tdata;
                        state  <= ST_RESP;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        data_q      <= '1;
                        timeout_err <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        last_grant <= grant_id;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
